// File: rtl/dcache_pkg.sv
// Shared types, field widths and address-split helpers for the data cache.
package dcache_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W  = DATA_W << OFF_W;
  localparam int LADDR_W = ADDR_W - OFF_W;
  localparam int NLINES  = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty flags (reset), tag and data arrays (not reset).
// Reads are asynchronous on idx_i; writes happen at the clock edge.
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic              word_we_i,
  input  logic [DATA_W-1:0] word_data_i,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LINE_W-1:0] line_data_i,
  input  logic              dirty_clr_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o
);

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [LINE_W-1:0] data_q [NLINES];

  // Per-line status flags: a fill validates and cleans, a store dirties, a writeback cleans.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_we_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end else if (word_we_i) begin
        dirty_q[idx_i] <= 1'b1;
      end else if (dirty_clr_i) begin
        dirty_q[idx_i] <= 1'b0;
      end
    end
  end

  // Tag and data payload; contents are undefined until the first fill of a line.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][int'(off_i)*DATA_W +: DATA_W] <= word_data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
// d_hit is combinational so hits complete with zero latency; memory-side outputs are registered.
module d_cache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               re,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               d_hit,
  output logic               mem_re,
  output logic               mem_we,
  output logic [LADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_rdy
);

  state_e               state_q;
  logic                 mem_re_q;
  logic                 mem_we_q;
  logic [LADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]    mem_wdata_q;

  logic [TAG_W-1:0]     tag_in;
  logic [IDX_W-1:0]     idx_in;
  logic [OFF_W-1:0]     off_in;
  logic                 line_valid;
  logic                 line_dirty;
  logic [TAG_W-1:0]     line_tag;
  logic [LINE_W-1:0]    line_data;
  logic                 access;
  logic                 hit;
  logic                 word_we;
  logic                 line_we;
  logic                 dirty_clr;
  logic                 d_hit_d;
  logic [DATA_W-1:0]    rdata_d;

  assign tag_in = addr_tag(addr);
  assign idx_in = addr_idx(addr);
  assign off_in = addr_off(addr);

  dcache_array u_array (
    .clk_i       (clk),
    .rst_i       (rst),
    .idx_i       (idx_in),
    .off_i       (off_in),
    .word_we_i   (word_we),
    .word_data_i (wdata),
    .line_we_i   (line_we),
    .line_tag_i  (tag_in),
    .line_data_i (mem_rdata),
    .dirty_clr_i (dirty_clr),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data)
  );

  // Lookup, array write strobes and the pipeline-facing hit/load data.
  always_comb begin
    access    = re | we;
    hit       = line_valid & (line_tag == tag_in);
    word_we   = 1'b0;
    line_we   = 1'b0;
    dirty_clr = 1'b0;
    d_hit_d   = 1'b0;
    rdata_d   = '0;
    case (state_q)
      IDLE: begin
        d_hit_d = ~access | hit;
        word_we = we & hit;
        if (re & ~we & hit) begin
          rdata_d = line_data[int'(off_in)*DATA_W +: DATA_W];
        end else begin
          rdata_d = '0;
        end
      end
      WB:      dirty_clr = mem_rdy;
      FILL:    line_we   = mem_rdy;
      DONE:    d_hit_d   = 1'b0;
      default: d_hit_d   = 1'b0;
    endcase
  end

  // Miss sequencer: writeback of a dirty victim, line fill, then one bubble before re-lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {line_tag, idx_in};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= FILL;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {tag_in, idx_in};
            end
          end
        end
        WB: begin
          if (mem_rdy) begin
            state_q    <= FILL;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= {tag_in, idx_in};
          end
        end
        FILL: begin
          if (mem_rdy) begin
            state_q  <= DONE;
            mem_re_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_hit     = d_hit_d;
  assign rdata     = rdata_d;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench for d_cache_ctrl: directed scenarios plus random accesses
// checked against a line-level behavioural cache model and a backing memory.
module tb_d_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        d_hit;
  logic        mem_re, mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;

  int compared   = 0;
  int mismatched = 0;

  // behavioural model: per-line state and a sparse backing memory
  bit          mvalid [8];
  bit          mdirty [8];
  int          mtag   [8];
  logic [15:0] mdata  [8][4];
  logic [63:0] bmem   [int];

  d_cache_ctrl dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .d_hit(d_hit), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  // One pipeline access; returns the load data observed in the completing cycle.
  task automatic do_access(input bit r, input bit w, input logic [15:0] a,
                           input logic [15:0] wd, input int dwb, input int dfill,
                           output logic [15:0] obs_rd);
    int off, idx, tg, cyc, wb_cyc, fill_cyc, exp_total;
    bit miss, exp_wb, done;
    int wb_la, fill_la;
    logic [63:0] wb_line, fill_line;
    logic [15:0] exp_rd;
    off = a % 4;
    idx = (a / 4) % 8;
    tg  = a / 32;
    miss    = !(mvalid[idx] && mtag[idx] == tg);
    exp_wb  = miss && mvalid[idx] && mdirty[idx];
    wb_la   = mtag[idx] * 8 + idx;
    wb_line = {mdata[idx][3], mdata[idx][2], mdata[idx][1], mdata[idx][0]};
    fill_la = tg * 8 + idx;
    if (!bmem.exists(fill_la)) bmem[fill_la] = {$urandom, $urandom};
    fill_line = bmem[fill_la];
    if (miss) begin
      if (exp_wb) bmem[wb_la] = wb_line;
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
      mtag[idx]   = tg;
      for (int k = 0; k < 4; k++) mdata[idx][k] = fill_line[16*k +: 16];
    end
    if (w) begin
      mdata[idx][off] = wd;
      mdirty[idx]     = 1'b1;
    end
    exp_rd = (r && !w) ? mdata[idx][off] : 16'h0000;
    exp_total = miss ? (3 + (exp_wb ? dwb : 0) + dfill) : 1;

    re = r; we = w; addr = a; wdata = wd;
    cyc = 0; wb_cyc = 0; fill_cyc = 0; done = 1'b0; obs_rd = 16'h0000;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_rdy = 1'b0;
      if (d_hit) begin
        done   = 1'b1;
        obs_rd = rdata;
        if (r && !w) chk("rdata", rdata, exp_rd);
        chk("idle_mem_re", mem_re, 1'b0);
        chk("idle_mem_we", mem_we, 1'b0);
      end else if (mem_we) begin
        wb_cyc++;
        chk("wb_expected", mem_we, exp_wb);
        chk("wb_before_fill", fill_cyc, 0);
        chk("wb_mem_re", mem_re, 1'b0);
        chk("wb_addr", mem_addr, 14'(wb_la));
        chk("wb_data", mem_wdata, wb_line);
        if (wb_cyc == dwb) begin
          mem_rdata = {$urandom, $urandom};
          mem_rdy   = 1'b1;
        end
      end else if (mem_re) begin
        fill_cyc++;
        chk("fill_addr", mem_addr, 14'(fill_la));
        if (fill_cyc == dfill) begin
          mem_rdata = fill_line;
          mem_rdy   = 1'b1;
        end
      end
    end
    if (!done) chk("access_timeout", 1'b0, 1'b1);
    chk("latency", cyc, exp_total);
    chk("wb_cycles", wb_cyc, exp_wb ? dwb : 0);
    chk("fill_cycles", fill_cyc, miss ? dfill : 0);
    @(posedge clk);
    #1;
    re = 1'b0; we = 1'b0; mem_rdy = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int a;
    re = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    mem_rdata = 64'h0; mem_rdy = 1'b0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_d_hit", d_hit, 1'b1);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 14'h0000);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    @(posedge clk); #1;

    // cold read miss, fill after 5 cycles
    bmem[4] = 64'h4444_3333_2222_1111;
    do_access(1'b1, 1'b0, 16'h0012, 16'h0000, 1, 5, rd);
    chk("t1_rdata", rd, 16'h3333);

    // read hit
    do_access(1'b1, 1'b0, 16'h0011, 16'h0000, 1, 1, rd);
    chk("t2_rdata", rd, 16'h2222);

    // dirty eviction
    do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 1, rd);
    do_access(1'b1, 1'b0, 16'h0210, 16'h0000, 3, 2, rd);
    chk("t3_bmem_word0", bmem[4][15:0], 16'hBEEF);

    // write-miss allocate into an invalid line, then read back and evict
    do_access(1'b0, 1'b1, 16'h0123, 16'hA5A5, 1, 2, rd);
    do_access(1'b1, 1'b0, 16'h0123, 16'h0000, 1, 1, rd);
    chk("t4_rdata", rd, 16'hA5A5);
    do_access(1'b1, 1'b0, 16'h0003, 16'h0000, 2, 1, rd);

    // slow memory: 20-cycle writeback
    do_access(1'b0, 1'b1, 16'h0130, 16'h1234, 1, 1, rd);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 20, 3, rd);

    // mem_rdy while idle is ignored
    @(negedge clk); mem_rdy = 1'b1;
    @(negedge clk); mem_rdy = 1'b0;
    chk("stray_rdy_re", mem_re, 1'b0);
    chk("stray_rdy_we", mem_we, 1'b0);
    chk("stray_rdy_hit", d_hit, 1'b1);
    @(posedge clk); #1;

    // randomized accesses over a few tags to mix hits, clean and dirty misses
    for (int n = 0; n < 80; n++) begin
      bit isw;
      a   = $urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
      isw = $urandom_range(0, 1);
      do_access(!isw, isw, 16'(a), 16'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), rd);
    end

    // reset in the middle of a fill
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    model_clear();
    re = 1'b1; addr = 16'h0456;
    begin
      int guard = 0;
      @(negedge clk);
      while (!mem_re && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      chk("t5_fill_started", mem_re, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rst_mem_re", mem_re, 1'b0);
      chk("t5_rst_mem_we", mem_we, 1'b0);
      @(posedge clk); #1;
      re = 1'b0;
      rst = 1'b0;
      model_clear();
    end
    @(negedge clk);
    chk("t5_post_rst_hit", d_hit, 1'b1);
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 16'h0456, 16'h0000, 1, 2, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
